// File: rtl/qrisc32_mem_arbiter_pkg.sv
// qrisc32_mem_arbiter_pkg: shared FSM states, requester indices and latched command type for the SRAM arbiter.
package risc_pack;
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} arb_state_t;
  localparam logic [1:0] ARB_IF = 2'd0;
  localparam logic [1:0] ARB_DR = 2'd1;
  localparam logic [1:0] ARB_DW = 2'd2;
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  typedef struct packed {
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic              is_write;
    logic [1:0]        owner;
  } arb_cmd_t;
endpackage

// File: rtl/qrisc32_arb_pick.sv
// qrisc32_arb_pick: picks one requester as a one-hot grant {dw,dr,if}.
// QRISC32_ARB_RR_EN selects round-robin from ptr; otherwise fixed priority dw > dr > if.
module qrisc32_arb_pick
  import risc_pack::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);
  logic [2:0] elig;
  assign elig = req & ~mask;
`ifdef QRISC32_ARB_RR_EN
  logic [2:0] rot;
  logic [2:0] first;
  logic [5:0] back;
  // rotate so ptr sits at bit 0, take the lowest set bit, rotate back
  assign rot   = 3'({elig, elig} >> ptr);
  assign first = rot & (~rot + 3'd1);
  assign back  = {3'b000, first} << ptr;
  assign gnt   = back[2:0] | back[5:3];
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign gnt = elig[ARB_DW] ? 3'b100 : elig[ARB_DR] ? 3'b010 : {2'b00, elig[ARB_IF]};
`endif
endmodule

// File: rtl/qrisc32_mem_arbiter.sv
// qrisc32_mem_arbiter: shares one single-port SRAM between fetch, data-read and data-write,
// one access at a time, with RD_LAT-cycle read latency and wait-state stalls.
module qrisc32_mem_arbiter
  import risc_pack::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dr_req,
  input  logic [AW-1:0] dr_addr,
  output logic          dr_rvalid,
  output logic [DW-1:0] dr_rdata,
  input  logic          dw_req,
  input  logic [AW-1:0] dw_addr,
  input  logic [DW-1:0] dw_data,
  output logic          dw_ack,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_w,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_wait_req,
  input  logic [DW-1:0] mem_data_r,
  output logic [2:0]    grant,
  output logic          busy
);
  arb_state_t    state;
  arb_cmd_t      cmd;
  logic [2:0]    cnt;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [2:0]    pick;
  logic [AW-1:0] addr_sel;
  // responders this cycle are masked so a still-held request is not served twice
  qrisc32_arb_pick u_pick (
    .req ({dw_req, dr_req, if_req}),
    .mask({dw_ack, dr_rvalid, if_rvalid}),
    .ptr (ptr),
    .gnt (pick)
  );
  assign owner       = pick[ARB_DW] ? ARB_DW : pick[ARB_DR] ? ARB_DR : ARB_IF;
  assign addr_sel    = pick[ARB_DW] ? dw_addr : pick[ARB_DR] ? dr_addr : if_addr;
  assign mem_address = AW'(cmd.addr);
  assign mem_data_w  = DW'(cmd.wdata);
  assign busy        = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      ptr       <= ARB_IF;
      grant     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      if_rvalid <= 1'b0;
      dr_rvalid <= 1'b0;
      dw_ack    <= 1'b0;
      if_rdata  <= '0;
      dr_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dr_rvalid <= 1'b0;
      dw_ack    <= 1'b0;
      case (state)
        IDLE: if (|pick) begin
          state  <= CMD;
          grant  <= pick;
          cmd    <= '{addr: CMD_AW'(addr_sel), wdata: CMD_DW'(dw_data), is_write: pick[ARB_DW], owner: owner};
          mem_rd <= ~pick[ARB_DW];
          mem_wr <= pick[ARB_DW];
          ptr    <= owner == ARB_DW ? ARB_IF : owner + 2'd1;
        end
        CMD: if (!mem_wait_req) begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (cmd.is_write) begin
            dw_ack <= 1'b1;
            grant  <= '0;
            state  <= IDLE;
          end else begin
            cnt   <= 3'(RD_LAT - 1);
            state <= RDWAIT;
          end
        end
        RDWAIT: if (cnt == 3'd0) begin
          if (cmd.owner == ARB_DR) begin
            dr_rdata  <= mem_data_r;
            dr_rvalid <= 1'b1;
          end else begin
            if_rdata  <= mem_data_r;
            if_rvalid <= 1'b1;
          end
          grant <= '0;
          state <= IDLE;
        end else cnt <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/qrisc32_mem_arbiter.md
# qrisc32_mem_arbiter

Shares one Avalon-style single-port SRAM master between three requesters: instruction fetch (read-only), MEM-stage data read and MEM-stage data write. Sits between the fetch/MEM pipeline stages and the SRAM, sequencing one access at a time through a small FSM. It handles the 2-cycle SRAM read latency, returns read data to the winning requester and acknowledges writes.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `RD_LAT`, 2: cycles from accepted `mem_rd` (`mem_wait_req`=0) to valid `mem_data_r`; legal range 1..7.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch read request, level, held until `if_rvalid`.
- `if_addr` in AW: fetch address.
- `if_rvalid` out 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` out DW: fetch read data, held until the next fetch `rvalid`.
- `dr_req` in 1 / `dr_addr` in AW / `dr_rvalid` out 1 / `dr_rdata` out DW: data-read port, same rules as fetch.
- `dw_req` in 1 / `dw_addr` in AW / `dw_data` in DW: data-write request, held until `dw_ack`.
- `dw_ack` out 1: one-cycle pulse, write accepted by SRAM.
- `mem_address` out AW, `mem_data_w` out DW, `mem_rd` out 1, `mem_wr` out 1: SRAM command.
- `mem_wait_req` in 1: SRAM stall; command held while 1.
- `mem_data_r` in DW: SRAM read data.
- `grant` out 3: one-hot owner {dw,dr,if}; 0 when idle.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, CMD, RDWAIT.
- IDLE: evaluate eligible requests. Winner's address/data/type latched, `grant` set, go to CMD. No request: stay.
- CMD: `mem_rd` or `mem_wr` = 1 with latched address/data. Held unchanged while `mem_wait_req`=1.
  - Write accepted (`mem_wait_req`=0): `dw_ack` pulses next cycle; go to IDLE.
  - Read accepted: go to RDWAIT with latency counter = RD_LAT-1.
- RDWAIT: strobes low. Counter decrements each cycle. At 0, capture `mem_data_r` into the owner's rdata register, pulse its rvalid next cycle, go to IDLE.
- Arbitration: fixed priority dw > dr > if.
- A requester whose ack/rvalid is high this cycle is masked from arbitration this cycle. This prevents double service of a held request.
- Request dropped before grant: no access, no response.
- Inputs are sampled only at grant; later changes are ignored until response.
- Only one access is outstanding; no pipelining of reads.

## Timing
- Reset values: `mem_rd`, `mem_wr`, `if_rvalid`, `dr_rvalid`, `dw_ack`, `busy` = 0. `grant` = 0. `mem_address`, `mem_data_w`, `if_rdata`, `dr_rdata` = 0. FSM in IDLE, RR pointer = fetch.
- Write, no wait states: req seen cycle 0 → `mem_wr` cycle 1 → `dw_ack` cycle 2; earliest next grant in cycle 2.
- Read, RD_LAT=2, no wait states: req cycle 0 → `mem_rd` cycle 1 → data sampled cycle 3 → rvalid cycle 4.
- Each wait-state cycle adds exactly one cycle to either latency.
- Reset asserted mid-access: next cycle returns to IDLE with strobes low; the pending response is discarded (no ack/rvalid).
- Simultaneous requests in IDLE: exactly one grant; others wait, no loss.

## Configuration
- `QRISC32_ARB_RR_EN` defined: round-robin arbitration. A 2-bit pointer advances to the requester after the last granted one, so the worst-case wait is 2 accesses.
- Not defined: fixed priority dw > dr > if. Fetch can starve under continuous data traffic.

## Structure
- `risc_pack` holds:
  - `arb_state_t` enum (IDLE/CMD/RDWAIT).
  - Requester index constants `ARB_IF`=0, `ARB_DR`=1, `ARB_DW`=2.
  - A packed struct for the latched command (addr, wdata, is_write, owner).
- One sub-module: `qrisc32_arb_pick`, a combinational selector of request vector + mask + pointer → one-hot grant. It contains the `QRISC32_ARB_RR_EN` switch.

## Test plan
- Single write: `dw_addr`=0x10, `dw_data`=0xDEADBEEF, `mem_wait_req`=0 → `mem_wr` cycle 1 with that addr/data; `dw_ack` cycle 2; nothing else asserted.
- Single read, RD_LAT=2: `dr_addr`=0x20, SRAM returns 0x12345678 in cycle 3 → `dr_rvalid` cycle 4, `dr_rdata`=0x12345678; `if_rvalid` stays 0.
- All three request in cycle 0, fixed priority: grant order dw, dr, if; each served once; fetch rvalid last.
- Same stimulus with `QRISC32_ARB_RR_EN` and all three held continuously: grants rotate if→dr→dw→if.
- `mem_wait_req`=1 for 3 cycles during a read: `mem_rd`/`mem_address` held stable; rvalid delayed by exactly 3 cycles.
- Reset driven low in RDWAIT: next cycle `busy`=0, `grant`=0; no `dr_rvalid` ever appears for that access.
